// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Sequential radix-2 restoring divider. A 2*WIDTH-bit dividend and a
//   WIDTH-bit divisor yield a WIDTH-bit quotient and a WIDTH-bit remainder
//   (dividend = quotient*divisor + remainder). One quotient bit is produced
//   per clock behind a start/done handshake.
//
//   Optional feature macro: SEQ_DIV_SIGNED_EN
//     undefined : unsigned operands, latency WIDTH (early exits 1)
//     defined   : two's-complement operands, an extra FIXUP cycle applies the
//                 signs (latency WIDTH+1), overflow saturates toward the
//                 result sign.
//
//   Ports
//     clk, rst_n           clock, async active-low reset
//     start                request, sampled only while busy=0
//     dividend, divisor    operands, captured on the accepting edge
//     busy                 division in progress
//     done                 one-cycle pulse, results valid from this cycle
//     quotient, remainder  results, held until the next done pulse
//     div_by_zero          divisor was zero (valid with done)
//     overflow             quotient does not fit in WIDTH bits (valid with done)
module seq_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQ_DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, FIXUP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] dlo;       // dividend low bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;       // captured divisor (magnitude in signed mode)
  logic             early_dz;  // early exit pending: divide by zero
  logic             early_ov;  // early exit pending: quotient too wide

  // ---- operand conditioning at accept ----
  logic [2*WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0]   ds_mag;
  logic               ld_dz, ld_ov;
  logic [WIDTH-1:0]   sat_q;

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg, rneg, ld_qneg;
  assign dd_mag  = dividend[2*WIDTH-1] ? -dividend : dividend;
  assign ds_mag  = divisor[WIDTH-1]    ? -divisor  : divisor;
  assign ld_qneg = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
  // saturate toward the sign the true result would have had
  assign sat_q   = qneg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign dd_mag = dividend;
  assign ds_mag = divisor;
  assign sat_q  = '1;
`endif

  assign ld_dz = (divisor == '0);
  // quotient needs more than WIDTH bits iff the high half already holds a divisor
  assign ld_ov = !ld_dz && (dd_mag[2*WIDTH-1:WIDTH] >= ds_mag);

  // ---- one restoring step ----
  // rem < dvs is invariant, so the shifted trial fits in WIDTH+1 bits and the
  // kept result always fits back in WIDTH bits.
  logic [WIDTH:0]   trial, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, q_nx;

  assign trial  = {rem, dlo[WIDTH-1]};
  assign diff   = trial - {1'b0, dvs};
  assign qbit   = ~diff[WIDTH];
  assign rem_nx = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nx   = {dlo[WIDTH-2:0], qbit};

`ifdef SEQ_DIV_SIGNED_EN
  // ---- sign fixup on the magnitude result ----
  logic             fx_ov;
  logic [WIDTH-1:0] fx_q, fx_r;
  assign fx_ov = qneg ? (dlo > {1'b1, {(WIDTH-1){1'b0}}}) : dlo[WIDTH-1];
  assign fx_q  = fx_ov ? sat_q : (qneg ? -dlo : dlo);
  assign fx_r  = fx_ov ? '0    : (rneg ? -rem : rem);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      dlo         <= '0;
      dvs         <= '0;
      early_dz    <= 1'b0;
      early_ov    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      qneg        <= 1'b0;
      rneg        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // DONE shares the load path so a start in the done cycle is taken
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            cnt      <= '0;
            dvs      <= ds_mag;
            rem      <= dd_mag[2*WIDTH-1:WIDTH];
            // raw low half kept for the divide-by-zero remainder
            dlo      <= ld_dz ? dividend[WIDTH-1:0] : dd_mag[WIDTH-1:0];
            early_dz <= ld_dz;
            early_ov <= ld_ov;
`ifdef SEQ_DIV_SIGNED_EN
            qneg     <= ld_qneg;
            rneg     <= dividend[2*WIDTH-1];
`endif
          end
        end

        CALC: begin
          if (early_dz || early_ov) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= early_dz;
            overflow    <= early_ov;
            quotient    <= early_dz ? '1 : sat_q;
            remainder   <= early_dz ? dlo : '0;
          end else begin
            rem <= rem_nx;
            dlo <= q_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
`ifdef SEQ_DIV_SIGNED_EN
              state <= FIXUP;
`else
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
              quotient    <= q_nx;
              remainder   <= rem_nx;
`endif
            end
          end
        end

`ifdef SEQ_DIV_SIGNED_EN
        FIXUP: begin
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          overflow    <= fx_ov;
          quotient    <= fx_q;
          remainder   <= fx_r;
        end
`endif

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

`ifdef SEQ_DIV_SIGNED_EN
  localparam int          LAT = 17;
  localparam logic [15:0] OVQ = 16'h7FFF;
`else
  localparam int          LAT = 16;
  localparam logic [15:0] OVQ = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: {latency, quotient, remainder, div_by_zero, overflow}
  function automatic logic [41:0] model(input logic [31:0] dd, input logic [15:0] ds);
`ifdef SEQ_DIV_SIGNED_EN
    longint a, b, ma, mb, qt, rt;
    logic [15:0] sat;
    a   = longint'($signed(dd));
    b   = longint'($signed(ds));
    sat = ((a < 0) != (b < 0)) ? 16'h8000 : 16'h7FFF;
    if (b == 0) return {8'd1, 16'hFFFF, dd[15:0], 2'b10};
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    if ((ma >> 16) >= mb) return {8'd1, sat, 16'h0, 2'b01};
    qt = a / b;
    rt = a % b;
    if (qt > 32767 || qt < -32768) return {8'd17, sat, 16'h0, 2'b01};
    return {8'd17, qt[15:0], rt[15:0], 2'b00};
`else
    longint unsigned q, r;
    if (ds == 0) return {8'd1, 16'hFFFF, dd[15:0], 2'b10};
    q = longint'(dd) / longint'(ds);
    r = longint'(dd) % longint'(ds);
    if (q > 64'hFFFF) return {8'd1, 16'hFFFF, 16'h0, 2'b01};
    return {8'd16, q[15:0], r[15:0], 2'b00};
`endif
  endfunction

  // Issue one request (accepted at the next rising edge) and count edges to done.
  // Operands are scrambled after accept to show they were captured.
  task automatic do_op(input logic [31:0] dd, input logic [15:0] ds, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = ds;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    #12;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 35'd0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_exact;
    int lat;
    logic [41:0] got, exp;
    do_op(32'd3000000, 16'd3000, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'(LAT), 16'd1000, 16'd0, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL exact: got %h want %h", got, exp);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL exact_busy_in_done: got %b want 0", busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, quotient} !== {1'b0, 16'd1000}) begin
      n_err++; $display("FAIL done_one_cycle: got done=%b q=%h want 0/%h", done, quotient, 16'd1000);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [41:0] got, exp;
    do_op(32'd3000001, 16'd1000, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'(LAT), 16'd3000, 16'd1, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL remainder: got %h want %h", got, exp);
    end
    // start in the done cycle; results must hold while the new run is busy
    @(negedge clk);
    start = 1'b1; dividend = 32'd32000000; divisor = 16'd32000;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({busy, done, quotient, remainder} !== {1'b1, 1'b0, 16'd3000, 16'd1}) begin
      n_err++;
      $display("FAIL b2b_accept_hold: got busy=%b done=%b q=%h r=%h want 1/0/%h/%h",
               busy, done, quotient, remainder, 16'd3000, 16'd1);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'(LAT), 16'd1000, 16'd0, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL b2b_result: got %h want %h", got, exp);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [41:0] got, exp;
    do_op(32'h0001_2345, 16'd0, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'd1, 16'hFFFF, 16'h2345, 2'b10};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL div_by_zero: got %h want %h", got, exp);
    end
  endtask

  task automatic test_overflow;
    int lat;
    logic [41:0] got, exp;
    do_op(32'h0005_0000, 16'd5, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'd1, OVQ, 16'h0, 2'b01};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL overflow: got %h want %h", got, exp);
    end
    // boundary: high half one below the divisor still fits
    do_op(32'h0004_FFFF, 16'd5, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = model(32'h0004_FFFF, 16'd5);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL overflow_edge: got %h want %h", got, exp);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    logic [41:0] got, exp;
    @(negedge clk);
    start = 1'b1; dividend = 32'd1234567; divisor = 16'd321;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin start = 1'b1; dividend = 32'd99; divisor = 16'd7; end
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 5) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL busy_mid_run: got %b want 1", busy);
        end
      end
      if (done) begin lat = k; break; end
    end
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = model(32'd1234567, 16'd321);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL busy_ignore: got %h want %h", got, exp);
    end
    lat = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    n_cmp++;
    if (lat != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL no_queued_start: got %0d extra done, busy=%b want 0/0", lat, busy);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    start = 1'b1; dividend = 32'd500000; divisor = 16'd777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (done) pulses++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (25) begin @(posedge clk); #1; if (done || busy) pulses++; end
    n_cmp++;
    if (pulses != 0) begin
      n_err++; $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", pulses);
    end
  endtask

  task automatic test_random;
    int lat, mode;
    logic [31:0] dd;
    logic [15:0] ds;
    logic [41:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      ds   = 16'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0) ds = 16'd0;
      if (mode <= 1 || ds == 0) dd = $urandom;
      else dd = {16'($urandom % ds), 16'($urandom)};
      do_op(dd, ds, lat);
      got = {8'(lat), quotient, remainder, div_by_zero, overflow};
      exp = model(dd, ds);
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL random[%0d] %h/%h: got %h want %h", i, dd, ds, got, exp);
      end
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed;
    int lat;
    logic [41:0] got, exp;
    do_op(32'hFFFF_FFF9, 16'd2, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'd17, 16'hFFFD, 16'hFFFF, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL signed_m7_2: got %h want %h", got, exp);
    end
    do_op(32'hFFFF_8000, 16'd1, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'd17, 16'h8000, 16'h0000, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL signed_min: got %h want %h", got, exp);
    end
    do_op(32'h0000_8000, 16'd1, lat);
    got = {8'(lat), quotient, remainder, div_by_zero, overflow};
    exp = {8'd17, 16'h7FFF, 16'h0000, 2'b01};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL signed_pos_ovf: got %h want %h", got, exp);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_exact;
    test_back_to_back;
    test_div_zero;
    test_overflow;
    test_busy_ignore;
    test_reset_mid;
`ifdef SEQ_DIV_SIGNED_EN
    test_signed;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
